// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants: FSM state encoding, hold levels,
// CSR addresses and the instruction-address width.
package pipe_ctrl_pkg;

  localparam int INST_ADDR_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_W_MEPC    = 3'd2,
    ST_W_MSTATUS = 3'd3,
    ST_W_MCAUSE  = 3'd4,
    ST_VECTOR    = 3'd5
  } state_e;

  localparam logic [1:0] HOLD_NONE  = 2'b00;
  localparam logic [1:0] HOLD_PC    = 2'b01;
  localparam logic [1:0] HOLD_IF    = 2'b10;
  localparam logic [1:0] HOLD_ID    = 2'b11;

  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  localparam logic [31:0] IRQ_CAUSE_EXT = 32'h8000_000B;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline control: redirect/stall arbitration in IDLE plus a machine-mode
// interrupt entry sequencer that drains EX, saves mepc/mstatus/mcause, then vectors.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] IRQ_CAUSE   = IRQ_CAUSE_EXT,
  parameter logic [11:0] CSR_MEPC    = ADDR_MEPC,
  parameter logic [11:0] CSR_MSTATUS = ADDR_MSTATUS,
  parameter logic [11:0] CSR_MCAUSE  = ADDR_MCAUSE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       jump_req_ex,
  input  logic [INST_ADDR_WIDTH-1:0] jump_addr_ex,
  input  logic                       mret_ex,
  input  logic                       hold_req_ex,
  input  logic                       hold_req_bus,
  input  logic                       irq,
  input  logic                       irq_en,
  input  logic [INST_ADDR_WIDTH-1:0] pc_id,
  input  logic [31:0]                mtvec_i,
  input  logic [31:0]                mepc_i,
  input  logic [31:0]                mstatus_i,
  output logic                       jump_o,
  output logic [INST_ADDR_WIDTH-1:0] jump_addr_o,
  output logic [1:0]                 hold_o,
  output logic                       flush_o,
  output logic                       csr_we_o,
  output logic [11:0]                csr_waddr_o,
  output logic [31:0]                csr_wdata_o
);

  state_e                     state;
  logic [INST_ADDR_WIDTH-1:0] epc;
  logic                       irq_take;

  logic                       jump_c;
  logic [INST_ADDR_WIDTH-1:0] jump_addr_c;
  logic [1:0]                 hold_c;
  logic                       flush_c;
  logic                       csr_we_c;
  logic [11:0]                csr_waddr_c;
  logic [31:0]                csr_wdata_c;

  // Only the vector base is used; the mtvec mode bits are deliberately dropped.
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec_i[1:0];

  // Trap entry: MPIE takes the old MIE, MIE is cleared.
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms);
    logic [31:0] r;
    r    = ms;
    r[7] = ms[3];
    r[3] = 1'b0;
    return r;
  endfunction

  function automatic logic [INST_ADDR_WIDTH-1:0] vector_base(input logic [31:0] tvec);
    logic [31:0] base;
    base = {tvec[31:2], 2'b00};
    return base[INST_ADDR_WIDTH-1:0];
  endfunction

  // MRET outranks interrupt acceptance; a same-cycle jump only redirects the saved epc.
  assign irq_take = irq && irq_en && !mret_ex;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      epc   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (irq_take) begin
            epc   <= jump_req_ex ? jump_addr_ex : pc_id;
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!hold_req_ex) state <= ST_W_MEPC;
        end
        ST_W_MEPC:    state <= ST_W_MSTATUS;
        ST_W_MSTATUS: state <= ST_W_MCAUSE;
        ST_W_MCAUSE:  state <= ST_VECTOR;
        ST_VECTOR:    state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    jump_c      = 1'b0;
    jump_addr_c = '0;
    hold_c      = HOLD_NONE;
    flush_c     = 1'b0;
    csr_we_c    = 1'b0;
    csr_waddr_c = '0;
    csr_wdata_c = '0;
    case (state)
      ST_IDLE: begin
        if (jump_req_ex) begin
          jump_c      = 1'b1;
          jump_addr_c = jump_addr_ex;
          flush_c     = 1'b1;
        end else if (mret_ex) begin
          jump_c      = 1'b1;
          jump_addr_c = mepc_i[INST_ADDR_WIDTH-1:0];
          flush_c     = 1'b1;
        end else if (hold_req_ex) begin
          hold_c = HOLD_ID;
        end else if (hold_req_bus) begin
          hold_c = HOLD_IF;
        end
      end
      ST_DRAIN: begin
        hold_c  = HOLD_ID;
        flush_c = 1'b1;
      end
      ST_W_MEPC: begin
        hold_c      = HOLD_ID;
        csr_we_c    = 1'b1;
        csr_waddr_c = CSR_MEPC;
        csr_wdata_c = 32'(epc);
      end
      ST_W_MSTATUS: begin
        hold_c      = HOLD_ID;
        csr_we_c    = 1'b1;
        csr_waddr_c = CSR_MSTATUS;
        csr_wdata_c = mstatus_on_trap(mstatus_i);
      end
      ST_W_MCAUSE: begin
        hold_c      = HOLD_ID;
        csr_we_c    = 1'b1;
        csr_waddr_c = CSR_MCAUSE;
        csr_wdata_c = IRQ_CAUSE;
      end
      ST_VECTOR: begin
        jump_c      = 1'b1;
        jump_addr_c = vector_base(mtvec_i);
        flush_c     = 1'b1;
      end
      default: begin
        hold_c = HOLD_NONE;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held, regardless of live EX requests.
  always_comb begin
    jump_o      = rst ? 1'b0 : jump_c;
    jump_addr_o = rst ? '0   : jump_addr_c;
    hold_o      = rst ? HOLD_NONE : hold_c;
    flush_o     = rst ? 1'b0 : flush_c;
    csr_we_o    = rst ? 1'b0 : csr_we_c;
    csr_waddr_o = rst ? '0   : csr_waddr_c;
    csr_wdata_o = rst ? '0   : csr_wdata_c;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus queues hand-computed output
// snapshots, a negedge monitor pops and compares them.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_req_ex = 1'b0;
  logic [31:0] jump_addr_ex = '0;
  logic        mret_ex = 1'b0;
  logic        hold_req_ex = 1'b0;
  logic        hold_req_bus = 1'b0;
  logic        irq = 1'b0;
  logic        irq_en = 1'b0;
  logic [31:0] pc_id = '0;
  logic [31:0] mtvec_i = '0;
  logic [31:0] mepc_i = '0;
  logic [31:0] mstatus_i = '0;
  logic        jump_o;
  logic [31:0] jump_addr_o;
  logic [1:0]  hold_o;
  logic        flush_o;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .jump_req_ex(jump_req_ex), .jump_addr_ex(jump_addr_ex),
    .mret_ex(mret_ex), .hold_req_ex(hold_req_ex), .hold_req_bus(hold_req_bus),
    .irq(irq), .irq_en(irq_en), .pc_id(pc_id),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .mstatus_i(mstatus_i),
    .jump_o(jump_o), .jump_addr_o(jump_addr_o), .hold_o(hold_o), .flush_o(flush_o),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [80:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // {jump, addr, hold, flush, we, waddr, wdata}
  function automatic logic [80:0] pack(input logic j, input logic [31:0] ja,
                                       input logic [1:0] h, input logic f,
                                       input logic we, input logic [11:0] wa,
                                       input logic [31:0] wd);
    return {j, ja, h, f, we, wa, wd};
  endfunction

  function automatic logic [80:0] dut_out();
    return pack(jump_o, jump_addr_o, hold_o, flush_o, csr_we_o, csr_waddr_o, csr_wdata_o);
  endfunction

  task automatic chk(input string nm, input logic [80:0] got, input logic [80:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got j=%b a=%h h=%b f=%b we=%b wa=%h wd=%h, want j=%b a=%h h=%b f=%b we=%b wa=%h wd=%h",
                  nm, got[80], got[79:48], got[47:46], got[45], got[44], got[43:32], got[31:0],
                  want[80], want[79:48], want[47:46], want[45], want[44], want[43:32], want[31:0]);
  endtask

  task automatic expect_out(input string nm, input logic j, input logic [31:0] ja,
                            input logic [1:0] h, input logic f, input logic we,
                            input logic [11:0] wa, input logic [31:0] wd);
    exp_t e;
    e.name = nm;
    e.v    = pack(j, ja, h, f, we, wa, wd);
    exp_q.push_back(e);
  endtask

  task automatic exp_idle(input string nm);
    expect_out(nm, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 12'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    jump_req_ex = 0; jump_addr_ex = 0; mret_ex = 0; hold_req_ex = 0;
    hold_req_bus = 0; irq = 0; irq_en = 0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, dut_out(), e.v);
    end
  end

  initial begin
    // Outputs must be zero during reset even with a live jump request.
    jump_req_ex = 1; jump_addr_ex = 32'h100; hold_req_ex = 1;
    #3;
    chk("reset_outputs", dut_out(), '0);
    tick(); tick();
    clear_in();
    rst = 0;

    tick(); jump_req_ex = 1; jump_addr_ex = 32'h100;
    expect_out("jump_100", 1, 32'h100, 2'b00, 1, 0, 12'h0, 32'h0);
    tick(); clear_in(); hold_req_ex = 1; hold_req_bus = 1;
    expect_out("hold_ex_bus", 0, 32'h0, 2'b11, 0, 0, 12'h0, 32'h0);
    tick(); hold_req_ex = 0;
    expect_out("hold_bus", 0, 32'h0, 2'b10, 0, 0, 12'h0, 32'h0);
    tick(); clear_in();
    exp_idle("idle_none");
    tick(); mret_ex = 1; mepc_i = 32'h44; irq = 1; irq_en = 0;
    expect_out("mret_44", 1, 32'h44, 2'b00, 1, 0, 12'h0, 32'h0);
    tick(); mret_ex = 0;
    exp_idle("irq_masked");
    tick(); jump_req_ex = 1; jump_addr_ex = 32'h300; mret_ex = 1; hold_req_ex = 1; irq = 0;
    expect_out("prio_jump", 1, 32'h300, 2'b00, 1, 0, 12'h0, 32'h0);

    // Interrupt entry from pc_id, irq dropped right after acceptance.
    tick(); clear_in(); pc_id = 32'h40; mtvec_i = 32'h203; mstatus_i = 32'h8;
    irq = 1; irq_en = 1;
    exp_idle("irq_accept");
    tick(); irq = 0; jump_req_ex = 1; jump_addr_ex = 32'h500; hold_req_bus = 1;
    expect_out("drain", 0, 32'h0, 2'b11, 1, 0, 12'h0, 32'h0);
    tick();
    expect_out("w_mepc", 0, 32'h0, 2'b11, 0, 1, 12'h341, 32'h40);
    tick();
    expect_out("w_mstatus", 0, 32'h0, 2'b11, 0, 1, 12'h300, 32'h80);
    tick();
    expect_out("w_mcause", 0, 32'h0, 2'b11, 0, 1, 12'h342, 32'h8000000B);
    tick();
    expect_out("vector", 1, 32'h200, 2'b00, 1, 0, 12'h0, 32'h0);
    tick(); clear_in();
    exp_idle("post_vector");

    // Accept alongside a jump; EX busy keeps DRAIN for 3 cycles.
    tick(); jump_req_ex = 1; jump_addr_ex = 32'h80; irq = 1; irq_en = 1; hold_req_ex = 1;
    expect_out("accept_jump", 1, 32'h80, 2'b00, 1, 0, 12'h0, 32'h0);
    tick(); jump_req_ex = 0;
    expect_out("drain1", 0, 32'h0, 2'b11, 1, 0, 12'h0, 32'h0);
    tick();
    expect_out("drain2", 0, 32'h0, 2'b11, 1, 0, 12'h0, 32'h0);
    tick(); hold_req_ex = 0;
    expect_out("drain3", 0, 32'h0, 2'b11, 1, 0, 12'h0, 32'h0);
    tick();
    expect_out("w_mepc_80", 0, 32'h0, 2'b11, 0, 1, 12'h341, 32'h80);
    tick();
    expect_out("w_mstatus2", 0, 32'h0, 2'b11, 0, 1, 12'h300, 32'h80);
    tick();
    expect_out("w_mcause2", 0, 32'h0, 2'b11, 0, 1, 12'h342, 32'h8000000B);
    tick(); irq = 0;
    expect_out("vector2", 1, 32'h200, 2'b00, 1, 0, 12'h0, 32'h0);

    // Reset during W_MSTATUS with mstatus MIE clear.
    tick(); clear_in(); irq = 1; irq_en = 1; pc_id = 32'h60; mstatus_i = 32'h0;
    exp_idle("accept3");
    tick(); irq = 0;
    expect_out("drain_r", 0, 32'h0, 2'b11, 1, 0, 12'h0, 32'h0);
    tick();
    expect_out("w_mepc_60", 0, 32'h0, 2'b11, 0, 1, 12'h341, 32'h60);
    tick();
    expect_out("w_mstatus_0", 0, 32'h0, 2'b11, 0, 1, 12'h300, 32'h0);
    @(negedge clk); #1;
    rst = 1;
    #1;
    chk("async_reset_outputs", dut_out(), '0);
    tick();
    rst = 0;
    exp_idle("after_rst1");
    tick();
    exp_idle("after_rst2");
    tick();
    exp_idle("after_rst3");
    tick();
    jump_req_ex = 1; jump_addr_ex = 32'h124;
    expect_out("idle_after_rst", 1, 32'h124, 2'b00, 1, 0, 12'h0, 32'h0);
    tick(); clear_in();
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
